// File: rtl/ahb_apb_bridge_pkg.sv
// ahb_apb_bridge_pkg
// Shared definitions for the AHB-lite to APB bridge: htrans and hresp
// encodings, the OKAY/ERROR response constants, the bridge FSM state
// enum and a helper that classifies a transfer type as active.
`timescale 1ns/1ps
package ahb_apb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_e;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_active_trans(input logic [1:0] trans);
    logic active;
    case (trans)
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      default:                   active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/ahb_apb_dec.sv
// ahb_apb_dec
// Combinational address decoder. Slave i owns the window
// [BASE_ADDR + i*2^WIN_LOG2, BASE_ADDR + (i+1)*2^WIN_LOG2 - 1].
// Addresses below BASE_ADDR never hit: the subtraction is not allowed
// to wrap into a valid window.
// Ports:
//   addr_i  in  32       address to decode
//   sel_o   out NUM_SLV  one-hot slave select (all zero on a miss)
//   hit_o   out 1        address falls inside one of the windows
`timescale 1ns/1ps
module ahb_apb_dec
  import ahb_apb_bridge_pkg::*;
#(
  parameter int          NUM_SLV   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h00A0_0000,
  parameter int          WIN_LOG2  = 16
) (
  input  logic [31:0]        addr_i,
  output logic [NUM_SLV-1:0] sel_o,
  output logic               hit_o
);

  logic [31:0] off_s;
  logic [31:0] idx_s;

  assign off_s = addr_i - BASE_ADDR;
  assign idx_s = off_s >> WIN_LOG2;
  assign hit_o = (addr_i >= BASE_ADDR) && (idx_s < 32'(NUM_SLV));

  // Expand the window index into a one-hot select, gated by the hit flag.
  always_comb begin
    sel_o = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_o[i] = hit_o && (idx_s == 32'(i));
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_n.sv
// ahb_apb_bridge_n
// AHB-lite slave to APB master bridge serving NUM_SLV APB slaves on a
// single clock. Each AHB transfer becomes one APB SETUP + ACCESS pair;
// unmapped addresses and APB slave errors produce the two-cycle AHB
// ERROR response.
// Optional feature: define AHB_APB_BRIDGE_N_TIMEOUT_EN to abort an APB
// access after TIMEOUT pready-low ACCESS cycles (ERROR response).
// Without it ACCESS waits indefinitely and no counter exists.
// Ports:
//   hclk, hreset            clock, async active-high reset
//   hsel, hready_in, hwrite AHB select, bus ready, direction
//   haddr, hwdata, htrans   AHB address, write data, transfer type
//   hrdata, hready, hresp   AHB read data and response
//   paddr, pwdata           APB address and write data
//   pwrite, penable         APB direction and enable strobe
//   psel                    APB one-hot slave select (NUM_SLV)
//   pready, pslverr         APB per-slave ready / error (NUM_SLV)
//   prdata                  APB read data, slave i at [32i+31:32i]
`timescale 1ns/1ps
module ahb_apb_bridge_n
  import ahb_apb_bridge_pkg::*;
#(
  parameter int          NUM_SLV   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h00A0_0000,
  parameter int          WIN_LOG2  = 16,
  parameter int          TIMEOUT   = 255
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic                   hsel,
  input  logic                   hready_in,
  input  logic                   hwrite,
  input  logic [31:0]            haddr,
  input  logic [31:0]            hwdata,
  input  logic [1:0]             htrans,
  output logic [31:0]            hrdata,
  output logic                   hready,
  output logic [1:0]             hresp,
  output logic [31:0]            paddr,
  output logic [31:0]            pwdata,
  output logic                   pwrite,
  output logic                   penable,
  output logic [NUM_SLV-1:0]     psel,
  input  logic [NUM_SLV-1:0]     pready,
  input  logic [NUM_SLV-1:0]     pslverr,
  input  logic [32*NUM_SLV-1:0]  prdata
);

  state_e               state_q, state_d;
  logic [31:0]          paddr_q;
  logic [31:0]          pwdata_q;
  logic                 pwrite_q;
  logic [NUM_SLV-1:0]   sel_q;

  logic                 valid_s;
  logic                 accept_s;
  logic                 dec_hit_s;
  logic [NUM_SLV-1:0]   dec_sel_s;
  logic                 slv_ready_s;
  logic                 slv_err_s;
  logic [31:0]          slv_rdata_s;
  logic                 tmo_hit_s;

  ahb_apb_dec #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR),
    .WIN_LOG2  (WIN_LOG2)
  ) u_dec (
    .addr_i (haddr),
    .sel_o  (dec_sel_s),
    .hit_o  (dec_hit_s)
  );

  assign valid_s = hsel & hready_in & is_active_trans(htrans);
  // A new transfer is taken only in cycles where this bridge itself
  // signals hready=1 (IDLE, good ACCESS completion, ERR2).
  assign accept_s = valid_s & hready;

  assign slv_ready_s = |(pready & sel_q);
  assign slv_err_s   = |(pslverr & sel_q);

  assign paddr  = paddr_q;
  assign pwrite = pwrite_q;
  // hwdata arrives in the SETUP cycle (AHB data phase); it is shown
  // directly then and held from the register during ACCESS.
  assign pwdata = (state_q == ST_SETUP) ? hwdata : pwdata_q;

  // Read data mux for the selected slave (one-hot AND-OR).
  always_comb begin
    slv_rdata_s = 32'h0000_0000;
    for (int i = 0; i < NUM_SLV; i++) begin
      slv_rdata_s = slv_rdata_s | (prdata[i*32 +: 32] & {32{sel_q[i]}});
    end
  end

`ifdef AHB_APB_BRIDGE_N_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Count pready-low ACCESS cycles; flag the TIMEOUT-th one.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_hit_s = 1'b0;
    if ((state_q == ST_ACCESS) && !slv_ready_s) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
        tmo_hit_s = 1'b1;
        tmo_cnt_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic [31:0] tmo_unused_s;
  assign tmo_unused_s = 32'(TIMEOUT);
  assign tmo_hit_s    = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept_s) begin
          state_d = dec_hit_s ? ST_SETUP : ST_ERR1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (slv_ready_s) begin
          if (slv_err_s) begin
            state_d = ST_ERR2;
          end else if (accept_s) begin
            state_d = dec_hit_s ? ST_SETUP : ST_ERR1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmo_hit_s) begin
          state_d = ST_ERR1;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: AHB response and APB select/enable.
  always_comb begin
    hready  = 1'b1;
    hresp   = HRESP_OKAY;
    hrdata  = 32'h0000_0000;
    psel    = '0;
    penable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hready = 1'b1;
      end
      ST_SETUP: begin
        hready = 1'b0;
        psel   = sel_q;
      end
      ST_ACCESS: begin
        psel    = sel_q;
        penable = 1'b1;
        if (slv_ready_s) begin
          if (slv_err_s) begin
            hready = 1'b0;
            hresp  = HRESP_ERROR;
          end else begin
            hready = 1'b1;
            hrdata = pwrite_q ? 32'h0000_0000 : slv_rdata_s;
          end
        end else begin
          hready = 1'b0;
        end
      end
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = HRESP_ERROR;
      end
      ST_ERR2: begin
        hready = 1'b1;
        hresp  = HRESP_ERROR;
      end
      default: begin
        hready = 1'b1;
      end
    endcase
  end

  // Address-phase capture and write-data hold for the APB side.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      paddr_q  <= 32'h0000_0000;
      pwrite_q <= 1'b0;
      sel_q    <= '0;
      pwdata_q <= 32'h0000_0000;
    end else begin
      // Unmapped transfers leave the APB bus untouched.
      if (accept_s && dec_hit_s) begin
        paddr_q  <= haddr;
        pwrite_q <= hwrite;
        sel_q    <= dec_sel_s;
      end
      if (state_q == ST_SETUP) begin
        pwdata_q <= hwdata;
      end
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_n.sv
`timescale 1ns/1ps
module tb_ahb_apb_bridge_n;
  import ahb_apb_bridge_pkg::*;

  localparam int NS = 8;

  logic              hclk = 1'b0;
  logic              hreset;
  logic              hsel, hready_in, hwrite;
  logic [31:0]       haddr, hwdata;
  logic [1:0]        htrans;
  logic [31:0]       hrdata;
  logic              hready;
  logic [1:0]        hresp;
  logic [31:0]       paddr, pwdata;
  logic              pwrite, penable;
  logic [NS-1:0]     psel, pready, pslverr;
  logic [32*NS-1:0]  prdata;

  ahb_apb_bridge_n #(
    .NUM_SLV(NS), .BASE_ADDR(32'h00A0_0000), .WIN_LOG2(16), .TIMEOUT(4)
  ) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .hready_in(hready_in),
    .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .htrans(htrans),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .paddr(paddr),
    .pwdata(pwdata), .pwrite(pwrite), .penable(penable), .psel(psel),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
    logic        err;
    logic        hit;
    int          slot;
    int          lat;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          lat;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  vec_t vecs[11];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_prdata(input int slot, input logic [31:0] val);
    for (int j = 0; j < NS; j++) begin
      prdata[j*32 +: 32] = (j == slot) ? val : (32'hF00D_0000 | 32'(j));
    end
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = HTRANS_IDLE; haddr = 32'h0; hwrite = 1'b0;
    pready = '0; pslverr = '0;
  endtask

  task automatic run_xfer(input vec_t v, input int id);
    int   acc;
    logic done;
    exp_t e;
    @(negedge hclk);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = v.addr; hwrite = v.wr;
    hwdata = 32'h0; pready = '0; pslverr = '0;
    fill_prdata(v.hit ? v.slot : -1, v.data);
    #1;
    check($sformatf("v%0d addr_phase_hready", id), 32'(hready), 32'h1);
    e.lat = v.lat; e.resp = v.resp; e.rdata = v.rdata;
    sb_q.push_back(e);
    acc = 0;
    done = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge hclk);
      hsel = 1'b0; htrans = HTRANS_IDLE;
      hwdata = v.wr ? v.data : 32'h0;
      pready = '0; pslverr = '0;
      if (v.hit && penable && psel[v.slot[2:0]]) begin
        if (acc >= v.waits) begin
          pready[v.slot[2:0]]  = 1'b1;
          pslverr[v.slot[2:0]] = v.err;
        end
        acc++;
      end
      #1;
      if (!v.hit) begin
        check($sformatf("v%0d no_psel", id), 32'(psel), 32'h0);
      end else if (psel != '0 && !penable) begin
        check($sformatf("v%0d setup_psel", id), 32'(psel), 32'(1) << v.slot);
        check($sformatf("v%0d setup_paddr", id), paddr, v.addr);
        check($sformatf("v%0d setup_pwrite", id), 32'(pwrite), 32'(v.wr));
        if (v.wr) check($sformatf("v%0d setup_pwdata", id), pwdata, v.data);
      end
      if (hready) begin
        e = sb_q.pop_front();
        check($sformatf("v%0d latency", id), 32'(cyc), 32'(e.lat));
        check($sformatf("v%0d hresp", id), 32'(hresp), 32'(e.resp));
        check($sformatf("v%0d hrdata", id), hrdata, e.rdata);
        done = 1'b1;
      end else begin
        check($sformatf("v%0d hrdata_zero", id), hrdata, 32'h0);
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL v%0d hready_timeout: got no hready within 40 cycles, required %0d", id, v.lat);
      if (sb_q.size() > 0) e = sb_q.pop_front();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr    addr          data          wt err hit slot lat resp         rdata
    vecs[0]  = '{1'b1, 32'h00A1_0004, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 1, 2, HRESP_OKAY,  32'h0};
    vecs[1]  = '{1'b0, 32'h00A3_0000, 32'h1234_5678, 3, 1'b0, 1'b1, 3, 5, HRESP_OKAY,  32'h1234_5678};
    vecs[2]  = '{1'b1, 32'h00B0_0000, 32'h1111_1111, 0, 1'b0, 1'b0, 0, 2, HRESP_ERROR, 32'h0};
    vecs[3]  = '{1'b0, 32'h00A2_0010, 32'h2222_2222, 0, 1'b1, 1'b1, 2, 3, HRESP_ERROR, 32'h0};
    vecs[4]  = '{1'b0, 32'h00A7_FFFC, 32'hCAFE_F00D, 1, 1'b0, 1'b1, 7, 3, HRESP_OKAY,  32'hCAFE_F00D};
    vecs[5]  = '{1'b0, 32'h009F_FFFC, 32'h4444_4444, 0, 1'b0, 1'b0, 0, 2, HRESP_ERROR, 32'h0};
    vecs[6]  = '{1'b1, 32'h00A0_0000, 32'h0BAD_F00D, 2, 1'b0, 1'b1, 0, 4, HRESP_OKAY,  32'h0};
    vecs[7]  = '{1'b0, 32'h00A8_0000, 32'h6666_6666, 0, 1'b0, 1'b0, 0, 2, HRESP_ERROR, 32'h0};
    vecs[8]  = '{1'b1, 32'h00A5_1230, 32'h3333_3333, 2, 1'b1, 1'b1, 5, 5, HRESP_ERROR, 32'h0};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFC, 32'h9999_9999, 0, 1'b0, 1'b0, 0, 2, HRESP_ERROR, 32'h0};
    vecs[10] = '{1'b0, 32'h00A6_8000, 32'h5A5A_5A5A, 0, 1'b0, 1'b1, 6, 2, HRESP_OKAY,  32'h5A5A_5A5A};

    hreset = 1'b1; hready_in = 1'b1; hwdata = 32'h0; prdata = '0;
    idle_bus();
    repeat (2) @(negedge hclk);
    #1;
    check("rst_psel", 32'(psel), 32'h0);
    check("rst_penable", 32'(penable), 32'h0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_pwrite", 32'(pwrite), 32'h0);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_hready", 32'(hready), 32'h1);
    check("rst_hresp", 32'(hresp), 32'(HRESP_OKAY));
    @(negedge hclk);
    hreset = 1'b0;

    for (int i = 0; i < 11; i++) run_xfer(vecs[i], i);

    // Slave error, back-to-back NONSEQ in ERR2, then ACCESS -> SETUP.
    @(negedge hclk);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h00A2_0000; hwrite = 1'b0;
    pready = '0; pslverr = '0; fill_prdata(2, 32'h2020_2020);
    #1; check("b2b c0 hready", 32'(hready), 32'h1);
    @(negedge hclk);
    hsel = 1'b0; htrans = HTRANS_IDLE;
    #1; check("b2b c1 psel", 32'(psel), 32'h04);
    check("b2b c1 penable", 32'(penable), 32'h0);
    check("b2b c1 hready", 32'(hready), 32'h0);
    @(negedge hclk);
    pready[2] = 1'b1; pslverr[2] = 1'b1;
    #1; check("b2b c2 penable", 32'(penable), 32'h1);
    check("b2b c2 hready", 32'(hready), 32'h0);
    check("b2b c2 hresp", 32'(hresp), 32'(HRESP_ERROR));
    @(negedge hclk);
    pready = '0; pslverr = '0;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h00A4_0000; hwrite = 1'b0;
    fill_prdata(4, 32'h0A0B_0C0D);
    #1; check("b2b c3 psel", 32'(psel), 32'h0);
    check("b2b c3 hready", 32'(hready), 32'h1);
    check("b2b c3 hresp", 32'(hresp), 32'(HRESP_ERROR));
    @(negedge hclk);
    hsel = 1'b0; htrans = HTRANS_IDLE;
    #1; check("b2b c4 psel", 32'(psel), 32'h10);
    check("b2b c4 penable", 32'(penable), 32'h0);
    check("b2b c4 paddr", paddr, 32'h00A4_0000);
    @(negedge hclk);
    pready[4] = 1'b1;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h00A0_0040; hwrite = 1'b1;
    #1; check("b2b c5 hready", 32'(hready), 32'h1);
    check("b2b c5 hresp", 32'(hresp), 32'(HRESP_OKAY));
    check("b2b c5 hrdata", hrdata, 32'h0A0B_0C0D);
    @(negedge hclk);
    pready = '0; hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h7777_0000;
    #1; check("b2b c6 psel", 32'(psel), 32'h01);
    check("b2b c6 paddr", paddr, 32'h00A0_0040);
    check("b2b c6 pwrite", 32'(pwrite), 32'h1);
    check("b2b c6 pwdata", pwdata, 32'h7777_0000);
    @(negedge hclk);
    pready[0] = 1'b1;
    #1; check("b2b c7 hready", 32'(hready), 32'h1);
    check("b2b c7 hrdata", hrdata, 32'h0);
    check("b2b c7 pwdata", pwdata, 32'h7777_0000);

    // Reset pulse during ACCESS.
    @(negedge hclk);
    pready = '0; hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h00A1_0008; hwrite = 1'b1;
    @(negedge hclk);
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h55AA_55AA;
    #1; check("rstx c1 psel", 32'(psel), 32'h02);
    @(negedge hclk);
    #1; check("rstx c2 penable", 32'(penable), 32'h1);
    check("rstx c2 paddr", paddr, 32'h00A1_0008);
    hreset = 1'b1;
    #1;
    check("rstx psel", 32'(psel), 32'h0);
    check("rstx penable", 32'(penable), 32'h0);
    check("rstx paddr", paddr, 32'h0);
    check("rstx pwdata", pwdata, 32'h0);
    check("rstx pwrite", 32'(pwrite), 32'h0);
    check("rstx hready", 32'(hready), 32'h1);
    check("rstx hresp", 32'(hresp), 32'(HRESP_OKAY));
    #1 hreset = 1'b0;
    idle_bus();
    run_xfer(vecs[0], 100);

    // Slave 0 never ready.
    @(negedge hclk);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h00A0_0100; hwrite = 1'b1;
    pready = '0; pslverr = '0;
    @(negedge hclk);
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h0000_00AA;
    #1; check("tmo c1 psel", 32'(psel), 32'h01);
`ifdef AHB_APB_BRIDGE_N_TIMEOUT_EN
    for (int c = 2; c <= 5; c++) begin
      @(negedge hclk);
      #1; check($sformatf("tmo c%0d penable", c), 32'(penable), 32'h1);
      check($sformatf("tmo c%0d hready", c), 32'(hready), 32'h0);
    end
    @(negedge hclk);
    #1; check("tmo c6 penable", 32'(penable), 32'h0);
    check("tmo c6 psel", 32'(psel), 32'h0);
    check("tmo c6 hready", 32'(hready), 32'h0);
    check("tmo c6 hresp", 32'(hresp), 32'(HRESP_ERROR));
    @(negedge hclk);
    #1; check("tmo c7 hready", 32'(hready), 32'h1);
    check("tmo c7 hresp", 32'(hresp), 32'(HRESP_ERROR));
`else
    for (int c = 2; c <= 7; c++) begin
      @(negedge hclk);
      #1; check($sformatf("wait c%0d penable", c), 32'(penable), 32'h1);
      check($sformatf("wait c%0d hready", c), 32'(hready), 32'h0);
    end
    @(negedge hclk);
    pready[0] = 1'b1;
    #1; check("wait c8 hready", 32'(hready), 32'h1);
    check("wait c8 hresp", 32'(hresp), 32'(HRESP_OKAY));
`endif
    @(negedge hclk);
    idle_bus();
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
